// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage master for the iterative divider. Latches operands,
// issues a one-cycle operand strobe, stalls EX until the result handshake, then
// writes HI/LO. Also handles exception flush and a no-response watchdog.
// Optional build macro: DIV_ZERO_BYPASS_EN (a zero divisor skips the divider and
// writes HI = dividend, LO = all ones directly).
module div_issue_ctrl #(
  parameter int unsigned MAX_WAIT = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_valid,
  input  logic        ex_div_sign,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        flush,
  output logic        ex_stall,
  output logic        div_opn_valid,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_sign,
  input  logic        div_res_valid,
  output logic        div_res_ready,
  input  logic [63:0] div_result,
  output logic        div_rst,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        div_timeout
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ABORT
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [31:0]        a_n, b_n, hi_n, lo_n;
  logic               sign_n, tmo_n;

  // Next-state, watchdog count and datapath capture
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    a_n     = div_a;
    b_n     = div_b;
    sign_n  = div_sign;
    hi_n    = hi_wdata;
    lo_n    = lo_wdata;
    tmo_n   = div_timeout;
    unique case (state)
      S_IDLE: begin
        if (ex_div_valid && !flush) begin
          a_n    = ex_rs;
          b_n    = ex_rt;
          sign_n = ex_div_sign;
`ifdef DIV_ZERO_BYPASS_EN
          if (ex_rt == 32'd0) begin
            hi_n    = ex_rs;
            lo_n    = 32'hFFFF_FFFF;
            state_n = S_DONE;
          end else begin
            state_n = S_ISSUE;
          end
`else
          state_n = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        cnt_n   = '0;
        state_n = flush ? S_ABORT : S_WAIT;
      end
      S_WAIT: begin
        // flush wins over a same-cycle result
        if (flush) begin
          state_n = S_ABORT;
        end else if (div_res_valid) begin
          hi_n    = div_result[63:32];
          lo_n    = div_result[31:0];
          state_n = S_DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
          if (cnt_n == CNT_W'(MAX_WAIT)) begin
            tmo_n   = 1'b1;
            state_n = S_ABORT;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ABORT: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      div_a         <= '0;
      div_b         <= '0;
      div_sign      <= 1'b0;
      hi_wdata      <= '0;
      lo_wdata      <= '0;
      div_timeout   <= 1'b0;
      div_opn_valid <= 1'b0;
      div_res_ready <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      div_a         <= a_n;
      div_b         <= b_n;
      div_sign      <= sign_n;
      hi_wdata      <= hi_n;
      lo_wdata      <= lo_n;
      div_timeout   <= tmo_n;
      div_opn_valid <= (state_n == S_ISSUE);
      div_res_ready <= (state_n == S_WAIT);
    end
  end

  // Pipeline stall, write strobe and divider reset depend on live inputs
  always_comb begin
    ex_stall = !rst && ((state == S_IDLE && ex_div_valid && !flush) ||
                        (state == S_ISSUE) || (state == S_WAIT) ||
                        (state == S_ABORT && ex_div_valid));
    hilo_we  = !rst && (state == S_DONE) && !flush;
    div_rst  = rst || (state == S_ABORT);
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: randomized bench for div_issue_ctrl against a transaction-
// level expectation model and a behavioural divider responder.
module tb_div_issue_ctrl;

  localparam int unsigned MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_div_valid, ex_div_sign, flush;
  logic [31:0] ex_rs, ex_rt;
  logic        ex_stall, div_opn_valid, div_sign, div_res_valid, div_res_ready;
  logic [31:0] div_a, div_b, hi_wdata, lo_wdata;
  logic [63:0] div_result;
  logic        div_rst, hilo_we, div_timeout;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        tmo_exp  = 1'b0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .ex_div_valid(ex_div_valid), .ex_div_sign(ex_div_sign),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .flush(flush), .ex_stall(ex_stall),
    .div_opn_valid(div_opn_valid), .div_a(div_a), .div_b(div_b), .div_sign(div_sign),
    .div_res_valid(div_res_valid), .div_res_ready(div_res_ready), .div_result(div_result),
    .div_rst(div_rst), .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .div_timeout(div_timeout)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Divider behaviour: {remainder, quotient}, truncating division; zero divisor
  // answers {dividend, all ones}.
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic sg);
    longint sa, sb;
    logic [63:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 64'(sa / sb);
      r  = 64'(sa % sb);
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ex_div_valid = 1'b1; flush = 1'b0; div_res_valid = 1'b0;
    #1;
    check("rst_div_rst", 64'(div_rst), 64'd1);
    check("rst_stall", 64'(ex_stall), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; ex_div_valid = 1'b0;
    tmo_exp = 1'b0;
    #1;
    check("rst_outs", {div_opn_valid, div_res_ready, hilo_we, div_sign, div_timeout,
                       ex_stall, div_rst}, 64'd0);
    check("rst_ab", {div_a, div_b}, 64'd0);
    check("rst_hilo", {hi_wdata, lo_wdata}, 64'd0);
  endtask

  // One instruction through EX. lat = WAIT cycle (1-based) on which the divider
  // answers; fl_wait = -1 none, 0 flush in ISSUE, k flush in WAIT cycle k;
  // fl_done = flush in the write-back cycle.
  task automatic run_div(input logic [31:0] rs, input logic [31:0] rt, input logic sg,
                         input int lat, input int hold, input int fl_wait, input bit fl_done,
                         output logic [31:0] hi_o, output logic [31:0] lo_o, output int occ);
    int iss, n_stall, n_opn, n_rdy, n_we, n_rst, we_c, tail, abort_c, done_c;
    int e_stall, e_rdy, e_rst;
    bit in_ex, bypass, fl, tmo, exp_we;
    logic [31:0] ma, mb;
    logic        ms;
    logic [63:0] exp_res;
    iss = -1; n_stall = 0; n_opn = 0; n_rdy = 0; n_we = 0; n_rst = 0; we_c = -1;
    tail = 0; in_ex = 1'b1; ma = '0; mb = '0; ms = 1'b0; hi_o = '0; lo_o = '0;
    bypass = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
    bypass = (rt == 32'd0);
`endif
    fl      = !bypass && (fl_wait >= 0);
    tmo     = !bypass && !fl && (lat > int'(MAX_WAIT));
    exp_we  = !fl && !tmo && !fl_done;
    done_c  = bypass ? 1 : lat + 2;
    abort_c = fl ? fl_wait + 2 : (tmo ? int'(MAX_WAIT) + 2 : -1);
    exp_res = bypass ? {rs, 32'hFFFF_FFFF} : div_ref(rs, rt, sg);
    e_stall = bypass ? 1 : (fl ? fl_wait + 2 : (tmo ? int'(MAX_WAIT) + 2 : lat + 2));
    e_rdy   = bypass ? 0 : (fl ? fl_wait : (tmo ? int'(MAX_WAIT) : lat));
    e_rst   = (fl || tmo) ? 1 : 0;
    if (tmo) tmo_exp = 1'b1;

    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == abort_c) in_ex = 1'b0;
      ex_div_valid  = in_ex;
      ex_rs         = rs;
      ex_rt         = rt;
      ex_div_sign   = sg;
      flush         = (fl && c == fl_wait + 1) || (fl_done && c == done_c);
      div_res_valid = (iss >= 0) && (c - iss >= lat) && (c - iss < lat + hold);
      div_result    = div_res_valid ? div_ref(ma, mb, ms) : {$urandom, $urandom};
      #1;
      if (ex_stall) n_stall++;
      if (div_opn_valid) begin
        n_opn++;
        if (iss < 0) begin
          iss = c; ma = div_a; mb = div_b; ms = div_sign;
        end
      end
      if (div_res_ready) n_rdy++;
      if (hilo_we) begin
        n_we++; we_c = c; hi_o = hi_wdata; lo_o = lo_wdata;
      end
      if (div_rst) n_rst++;
      if (in_ex && !ex_stall) in_ex = 1'b0;
      if (!in_ex) tail++;
      if (tail > 3) break;
    end
    @(negedge clk);
    ex_div_valid = 1'b0; flush = 1'b0; div_res_valid = 1'b0;

    check("completed", 64'(tail > 3), 64'd1);
    check("opn_count", 64'(n_opn), bypass ? 64'd0 : 64'd1);
    if (!bypass) begin
      check("div_a", 64'(ma), 64'(rs));
      check("div_b", 64'(mb), 64'(rt));
      check("div_sign", 64'(ms), 64'(sg));
    end
    check("stall_len", 64'(n_stall), 64'(e_stall));
    check("ready_len", 64'(n_rdy), 64'(e_rdy));
    check("we_count", 64'(n_we), exp_we ? 64'd1 : 64'd0);
    check("div_rst_len", 64'(n_rst), 64'(e_rst));
    if (exp_we) begin
      check("we_cycle", 64'(we_c), 64'(done_c));
      check("hilo", {hi_o, lo_o}, exp_res);
    end
    check("timeout", 64'(div_timeout), 64'(tmo_exp));
    occ = we_c + 1;
  endtask

  initial begin
    logic [31:0] hi, lo, rs, rt;
    logic        sg;
    int          occ, lat, hold, fw, mode;
    bit          fd;
    rst = 1'b1; ex_div_valid = 1'b0; ex_div_sign = 1'b0; ex_rs = '0; ex_rt = '0;
    flush = 1'b0; div_res_valid = 1'b0; div_result = '0;
    do_reset();

    // DIVU 100/7
    run_div(32'd100, 32'd7, 1'b0, 3, 1, -1, 1'b0, hi, lo, occ);
    check("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    // DIV -7/2
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 2, 1, -1, 1'b0, hi, lo, occ);
    check("div_m7_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    // response on 5th WAIT cycle held 3 cycles
    run_div(32'd1000, 32'd33, 1'b0, 5, 3, -1, 1'b0, hi, lo, occ);
    check("occupancy", 64'(occ), 64'd8);
    // flush on 3rd WAIT cycle, then DIVU 9/3
    run_div(32'd50, 32'd5, 1'b0, 6, 1, 3, 1'b0, hi, lo, occ);
    run_div(32'd9, 32'd3, 1'b0, 1, 1, -1, 1'b0, hi, lo, occ);
    check("divu_9_3", {hi, lo}, {32'd0, 32'd3});
    // zero divisor (bypass or pass-through)
    run_div(32'd5, 32'd0, 1'b0, 2, 1, -1, 1'b0, hi, lo, occ);
    check("div_by_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    // flush in write-back cycle and in ISSUE
    run_div(32'd77, 32'd4, 1'b0, 2, 1, -1, 1'b1, hi, lo, occ);
    run_div(32'd77, 32'd4, 1'b1, 2, 1, 0, 1'b0, hi, lo, occ);
    // watchdog: divider never answers; flag sticks across a later divide
    run_div(32'd7, 32'd3, 1'b0, int'(MAX_WAIT) + 20, 1, -1, 1'b0, hi, lo, occ);
    run_div(32'd8, 32'd3, 1'b0, 1, 1, -1, 1'b0, hi, lo, occ);
    do_reset();
    check("timeout_cleared", 64'(div_timeout), 64'd0);

    // flush in IDLE blocks acceptance
    @(negedge clk);
    ex_div_valid = 1'b1; flush = 1'b1; ex_rt = 32'd3;
    #1 check("idle_flush_stall", 64'(ex_stall), 64'd0);
    @(negedge clk);
    ex_div_valid = 1'b0; flush = 1'b0;
    #1 check("idle_flush_noissue", {div_opn_valid, div_res_ready}, 64'd0);

    // reset in the middle of a divide
    @(negedge clk);
    ex_div_valid = 1'b1; ex_rs = 32'd40; ex_rt = 32'd6;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 check("midrst_outs", {div_rst, ex_stall, hilo_we}, 64'b100);
    @(negedge clk);
    rst = 1'b0; ex_div_valid = 1'b0; div_res_valid = 1'b1; div_result = 64'h1234;
    #1 check("midrst_idle", {ex_stall, div_opn_valid, div_res_ready, hilo_we}, 64'd0);
    @(negedge clk);
    div_res_valid = 1'b0;
    #1 check("midrst_nowe", 64'(hilo_we), 64'd0);

    // randomized transactions
    for (int i = 0; i < 40; i++) begin
      rs   = $urandom;
      mode = int'($urandom_range(0, 7));
      if (mode == 0) rt = 32'd0;
      else if (mode < 4) rt = 32'($urandom_range(1, 20));
      else rt = $urandom;
      sg   = 1'($urandom_range(0, 1));
      lat  = int'($urandom_range(1, MAX_WAIT));
      hold = int'($urandom_range(1, 3));
      fw   = -1;
      fd   = 1'b0;
      mode = int'($urandom_range(0, 9));
      if (mode == 7) fw = int'($urandom_range(0, 32'(lat)));
      else if (mode == 8) fd = 1'b1;
      else if (mode == 9) lat = int'($urandom_range(MAX_WAIT + 1, MAX_WAIT + 3));
      run_div(rs, rt, sg, lat, hold, fw, fd, hi, lo, occ);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "simulation time limit");
  end

endmodule
